// File: rtl/i2c_master.sv
// Single-byte I2C master: START, address+R/W, ACK check, one data byte, STOP.
// Optional slave clock stretching support is enabled by defining I2C_MASTER_STRETCH_EN.
module i2c_master #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  inout  wire        scl,
  inout  wire        sda
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_START, ST_ADDR, ST_AACK, ST_WR, ST_WACK, ST_RD, ST_RACK, ST_STOP
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div, div_n;
  logic [1:0]       q, q_n;
  logic [2:0]       bit_idx, bit_n;
  logic [6:0]       addr_r;
  logic             rw_r;
  logic [7:0]       wdata_r;
  logic [7:0]       rx;
  logic             scl_low, sda_low;
  logic             scl_low_n, sda_low_n;
  logic [7:0]       addr_byte;
  logic             tick_c;
  logic             stall_c;
  logic             sample_c;

  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;

  assign addr_byte = {addr_r, rw_r};
  assign tick_c    = (div == DIV_MAX);

`ifdef I2C_MASTER_STRETCH_EN
  // Slave holds scl low after release: freeze the divider until the line rises
  assign stall_c = (state != ST_IDLE) && q[1] && (scl == 1'b0);
`else
  assign stall_c = 1'b0;
`endif

  assign sample_c = (state != ST_IDLE) && !stall_c && tick_c && (q == 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      div     <= '0;
      q       <= '0;
      bit_idx <= '0;
      scl_low <= 1'b0;
      sda_low <= 1'b0;
    end else begin
      state   <= state_n;
      div     <= div_n;
      q       <= q_n;
      bit_idx <= bit_n;
      scl_low <= scl_low_n;
      sda_low <= sda_low_n;
    end
  end

  // Next phase plus the line levels that phase starts with
  always_comb begin
    state_n   = state;
    div_n     = div;
    q_n       = q;
    bit_n     = bit_idx;
    scl_low_n = 1'b0;
    sda_low_n = 1'b0;

    if (state == ST_IDLE) begin
      div_n = '0;
      q_n   = '0;
      if (start) state_n = ST_START;
    end else if (!stall_c) begin
      if (tick_c) begin
        div_n = '0;
        q_n   = q + 2'd1;
        if (q == 2'd3) begin
          case (state)
            ST_START: begin
              state_n = ST_ADDR;
              bit_n   = 3'd7;
            end
            ST_ADDR: begin
              if (bit_idx == 3'd0) state_n = ST_AACK;
              else                 bit_n   = bit_idx - 3'd1;
            end
            ST_AACK: begin
              bit_n = 3'd7;
              if (ack_err)   state_n = ST_STOP;
              else if (rw_r) state_n = ST_RD;
              else           state_n = ST_WR;
            end
            ST_WR: begin
              if (bit_idx == 3'd0) state_n = ST_WACK;
              else                 bit_n   = bit_idx - 3'd1;
            end
            ST_WACK: state_n = ST_STOP;
            ST_RD: begin
              if (bit_idx == 3'd0) state_n = ST_RACK;
              else                 bit_n   = bit_idx - 3'd1;
            end
            ST_RACK: state_n = ST_STOP;
            ST_STOP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
          endcase
        end
      end else begin
        div_n = div + DIV_W'(1);
      end
    end

    case (state_n)
      ST_START: sda_low_n = q_n[1];
      ST_ADDR: begin
        scl_low_n = !q_n[1];
        sda_low_n = !addr_byte[bit_n];
      end
      ST_WR: begin
        scl_low_n = !q_n[1];
        sda_low_n = !wdata_r[bit_n];
      end
      ST_AACK, ST_WACK, ST_RD, ST_RACK: scl_low_n = !q_n[1];
      ST_STOP: begin
        scl_low_n = !q_n[1];
        sda_low_n = (q_n != 2'd3);
      end
      default: ;
    endcase
  end

  // Request latch, sampled bus bits and handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= '0;
      rw_r    <= 1'b0;
      wdata_r <= '0;
      rx      <= '0;
      rdata   <= 8'h00;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == ST_IDLE && start) begin
        addr_r  <= addr;
        rw_r    <= rw;
        wdata_r <= wdata;
        ack_err <= 1'b0;
        busy    <= 1'b1;
      end
      if (sample_c) begin
        if ((state == ST_AACK || state == ST_WACK) && sda) ack_err <= 1'b1;
        if (state == ST_RD) rx <= {rx[6:0], sda};
      end
      if (state == ST_RD && state_n == ST_RACK) rdata <= rx;
      if (state == ST_STOP && state_n == ST_IDLE) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Bench for i2c_master: pulled-up bus, behavioural slave at 7'h64 returning 8'hAA,
// table vectors, corner sequences and random transactions against a transaction-level model.
module tb_i2c_master;

  localparam int unsigned D     = 4;
  localparam int          LIMIT = 2000;
  localparam logic [6:0]  SLV_ADDR = 7'h64;

  logic       clk, rst, start, rw;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;
  logic       busy, done, ack_err;
  wire        scl, sda;

  pullup (scl);
  pullup (sda);

  logic sl_sda_low, sl_scl_low;
  assign sda = sl_sda_low ? 1'b0 : 1'bz;
  assign scl = sl_scl_low ? 1'b0 : 1'bz;

  i2c_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Behavioural slave, sampling the bus on the falling clk edge
  int         cnt = 0;
  int         stop_cnt = 0;
  int         last_cnt = 0;
  logic       matched = 1'b0, srw = 1'b0, mnack = 1'b0;
  logic [7:0] sh = '0, rx_sh = '0, slave_rx = '0;
  logic [7:0] slv_data;
  logic       ps = 1'b1, pd = 1'b1;
  logic       stretch_arm = 1'b0, stretching = 1'b0;
  int         st_k = 0;

  initial begin
    sl_sda_low = 1'b0;
    sl_scl_low = 1'b0;
    slv_data   = 8'hAA;
    forever begin
      @(negedge clk);
      if (stretching) begin
        st_k++;
        if (st_k == 2 * D + 20) begin
          stretching = 1'b0;
          sl_scl_low = 1'b0;
        end
      end
      if (ps && scl && pd && !sda) begin
        cnt = 0; matched = 1'b0; sl_sda_low = 1'b0;
      end else if (ps && scl && !pd && sda) begin
        stop_cnt++; last_cnt = cnt; cnt = 0; sl_sda_low = 1'b0;
      end else if (!ps && scl) begin
        cnt++;
        if (cnt <= 8) sh = {sh[6:0], sda};
        if (cnt == 8) begin matched = (sh[7:1] == SLV_ADDR); srw = sh[0]; end
        if (cnt >= 10 && cnt <= 17) rx_sh = {rx_sh[6:0], sda};
        if (cnt == 17 && matched && !srw) slave_rx = rx_sh;
        if (cnt == 18) mnack = sda;
      end else if (ps && !scl) begin
        sl_sda_low = 1'b0;
        if (cnt == 8 && matched) sl_sda_low = 1'b1;
        if (cnt >= 9 && cnt <= 16 && matched && srw) sl_sda_low = !slv_data[16 - cnt];
        if (cnt == 17 && matched && !srw) sl_sda_low = 1'b1;
        if (cnt == 7 && stretch_arm) begin
          stretching = 1'b1; st_k = 0; sl_scl_low = 1'b1;
        end
      end
      ps = scl;
      pd = sda;
    end
  end

  int done_cnt = 0;
  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  // One transaction from accept to done; cyc is the cycle index of done (-1 on timeout)
  task automatic run_txn(input logic [6:0] a, input logic r, input logic [7:0] w,
                         input bit repulse, output int cyc, output int busy1,
                         output int done_next, output int busy_after, output int err_after,
                         output int stops);
    int s0;
    s0 = stop_cnt;
    busy1 = 0;
    @(negedge clk);
    start = 1'b1; addr = a; rw = r; wdata = w;
    @(posedge clk);
    cyc = -1;
    for (int c = 1; c <= LIMIT; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b0; busy1 = int'(busy); end
      if (repulse && c == 40) begin start = 1'b1; addr = 7'h10; rw = ~r; wdata = ~w; end
      if (repulse && c == 41) start = 1'b0;
      if (done) begin cyc = c; break; end
    end
    @(negedge clk);
    done_next  = int'(done);
    busy_after = int'(busy);
    err_after  = int'(ack_err);
    stops      = stop_cnt - s0;
  endtask

  function automatic int exp_cycles(input logic err);
    return 4 * D * (1 + 9 + (err ? 0 : 9) + 1) + 1;
  endfunction

  typedef struct {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         exp_cyc;
    logic [7:0] exp_rx;
  } vec_t;

  vec_t tbl[5];
  logic [7:0] m_rdata, m_rx;

  initial begin
    int cyc, b1, dn, ba, ea, st, d0;
    logic [6:0] a;
    logic r, err;
    logic [7:0] w;

    tbl[0] = '{7'h64, 1'b0, 8'h3C, 1'b0, 8'h00, 321, 8'h3C};
    tbl[1] = '{7'h64, 1'b1, 8'h00, 1'b0, 8'hAA, 321, 8'h3C};
    tbl[2] = '{7'h10, 1'b0, 8'h55, 1'b1, 8'hAA, 177, 8'h3C};
    tbl[3] = '{7'h10, 1'b1, 8'h00, 1'b1, 8'hAA, 177, 8'h3C};
    tbl[4] = '{7'h64, 1'b0, 8'hC3, 1'b0, 8'hAA, 321, 8'hC3};

    rst = 1'b1; start = 1'b0; addr = '0; rw = 1'b0; wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_scl", int'(scl === 1'b1), 1);
    check("reset_sda", int'(sda === 1'b1), 1);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_ack_err", int'(ack_err), 0);
    check("reset_rdata", int'(rdata), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    foreach (tbl[i]) begin
      run_txn(tbl[i].addr, tbl[i].rw, tbl[i].wdata, 1'b0, cyc, b1, dn, ba, ea, st);
      check($sformatf("vec%0d_done_cycle", i), cyc, tbl[i].exp_cyc);
      check($sformatf("vec%0d_busy_c1", i), b1, 1);
      check($sformatf("vec%0d_ack_err", i), ea, int'(tbl[i].exp_err));
      check($sformatf("vec%0d_rdata", i), int'(rdata), int'(tbl[i].exp_rdata));
      check($sformatf("vec%0d_slave_rx", i), int'(slave_rx), int'(tbl[i].exp_rx));
      check($sformatf("vec%0d_done_pulse", i), dn, 0);
      check($sformatf("vec%0d_busy_after", i), ba, 0);
      check($sformatf("vec%0d_stop_seen", i), st, 1);
      if (tbl[i].exp_err) check($sformatf("vec%0d_no_data_bits", i), last_cnt, 10);
      if (tbl[i].rw && !tbl[i].exp_err) check($sformatf("vec%0d_master_nack", i), int'(mnack), 1);
    end
    m_rdata = 8'hAA;

    // Restart request while busy must not disturb the running write
    run_txn(7'h64, 1'b0, 8'h5A, 1'b1, cyc, b1, dn, ba, ea, st);
    check("repulse_done_cycle", cyc, 321);
    check("repulse_ack_err", ea, 0);
    check("repulse_slave_rx", int'(slave_rx), 8'h5A);
    repeat (5) @(negedge clk);
    check("repulse_not_accepted", int'(busy), 0);

    // Reset during address bit 4 (cycle 70, scl low phase)
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1; addr = 7'h64; rw = 1'b0; wdata = 8'h77;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (68) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_scl", int'(scl === 1'b1), 1);
    check("midrst_sda", int'(sda === 1'b1), 1);
    check("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (400) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    run_txn(7'h64, 1'b0, 8'hA5, 1'b0, cyc, b1, dn, ba, ea, st);
    check("post_rst_done_cycle", cyc, 321);
    check("post_rst_ack_err", ea, 0);
    check("post_rst_slave_rx", int'(slave_rx), 8'hA5);
    m_rx = 8'hA5;

    // Random transactions against the transaction-level model
    for (int i = 0; i < 16; i++) begin
      a   = ($urandom_range(0, 2) != 0) ? SLV_ADDR : 7'($urandom);
      r   = 1'($urandom);
      w   = 8'($urandom);
      err = (a != SLV_ADDR);
      if (!err && r)  m_rdata = slv_data;
      if (!err && !r) m_rx = w;
      run_txn(a, r, w, 1'b0, cyc, b1, dn, ba, ea, st);
      check($sformatf("rnd%0d_done_cycle", i), cyc, exp_cycles(err));
      check($sformatf("rnd%0d_ack_err", i), ea, int'(err));
      check($sformatf("rnd%0d_rdata", i), int'(rdata), int'(m_rdata));
      check($sformatf("rnd%0d_slave_rx", i), int'(slave_rx), int'(m_rx));
    end

`ifdef I2C_MASTER_STRETCH_EN
    stretch_arm = 1'b1;
    run_txn(7'h64, 1'b0, 8'h5C, 1'b0, cyc, b1, dn, ba, ea, st);
    stretch_arm = 1'b0;
    check("stretch_done_cycle", cyc, 321 + 20);
    check("stretch_ack_err", ea, 0);
    check("stretch_slave_rx", int'(slave_rx), 8'h5C);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
